// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch stage: instruction-bus request/response, the fetched
// instruction record and the fetch controller state encoding.
package fetch_ctrl_pkg;

    localparam logic [63:0] PCINIT = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_ctrl_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        stall;
    } fetch_data_t;

    localparam fetch_data_t FETCH_DATA_RESET = '{raw_instr: 32'd0, pc: 64'd0, stall: 1'b1};

    function automatic logic [63:0] next_pc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that catches an instruction returned while the
// downstream register is stalled.
module fetch_skid
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  fetch_data_t i_data,
    output fetch_data_t o_data,
    output logic        o_valid
);

    logic        r_valid;
    fetch_data_t r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the payload carries no reset; it is only observed while r_valid is set.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, runs one ibus request at a time, absorbs
// stalls in a skid entry and drops in-flight data on redirect. FETCH_PERF_EN adds counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PCINIT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF,
`ifdef FETCH_PERF_EN
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt,
    output logic [63:0] perf_discard_cnt,
`endif
    output logic        dataF_valid
);

    fetch_ctrl_state_t r_state;
    fetch_ctrl_state_t w_state_n;
    logic [63:0]       r_pc;
    logic [63:0]       r_inflight_addr;
    fetch_data_t       r_data;
    logic              r_dv;

    logic        w_can_issue;
    logic        w_req_valid;
    logic        w_complete;
    logic        w_consume;
    logic        w_deliver;
    logic        w_to_dataF;
    logic        w_to_skid;
    logic        w_skid_pop;
    logic        w_dv_n;
    logic        w_skid_n;
    logic        w_can_issue_n;
    logic        w_skid_valid;
    fetch_data_t w_skid_data;
    fetch_data_t w_fetched;
    logic        w_unused;

    assign w_unused = ^{iresp.addr_ok, iresp.data[63:32]};

    assign w_can_issue = ~w_skid_valid & ~(r_dv & stall) & ~redirect;
    assign w_req_valid = ~reset & (((r_state == IDLE) & w_can_issue) | (r_state == REQ) | (r_state == DISCARD));
    assign w_complete  = w_req_valid & iresp.data_ok;
    assign w_consume   = r_dv & ~stall;
    assign w_deliver   = w_complete & ~redirect & (r_state != DISCARD);
    assign w_to_dataF  = w_deliver & ~(r_dv & stall);
    assign w_to_skid   = w_deliver & r_dv & stall;
    assign w_skid_pop  = w_consume & w_skid_valid & ~redirect;

    // Occupancy after this edge decides whether a finishing REQ chains straight into the next one.
    assign w_dv_n        = ~redirect & (w_skid_pop | w_to_dataF | (r_dv & stall));
    assign w_skid_n      = ~redirect & (w_to_skid | (w_skid_valid & ~w_skid_pop));
    assign w_can_issue_n = ~w_skid_n & ~(w_dv_n & stall);

    assign w_fetched = '{raw_instr: iresp.data[31:0], pc: r_pc, stall: 1'b0};

    assign ireq.valid  = w_req_valid;
    assign ireq.addr   = (r_state == DISCARD) ? r_inflight_addr : r_pc;
    assign dataF       = '{raw_instr: r_data.raw_instr, pc: r_data.pc, stall: ~r_dv};
    assign dataF_valid = r_dv;

    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_state_n = (w_complete & ~w_can_issue_n) ? IDLE : REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_state_n = w_complete ? IDLE : DISCARD;
                end else if (w_complete) begin
                    w_state_n = w_can_issue_n ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (w_complete) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_to_skid),
        .i_pop   (w_skid_pop),
        .i_flush (redirect),
        .i_data  (w_fetched),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid)
    );

    // NOTE: clocked state uses <= only, so every block sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_pc            <= RESET_PC;
            r_inflight_addr <= 64'd0;
            r_data          <= FETCH_DATA_RESET;
            r_dv            <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_dv    <= w_dv_n;
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_deliver) begin
                r_pc <= next_pc(r_pc);
            end
            if ((r_state == REQ) & redirect & ~w_complete) begin
                r_inflight_addr <= r_pc;
            end
            if (w_skid_pop) begin
                r_data <= w_skid_data;
            end else if (w_to_dataF) begin
                r_data <= w_fetched;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [63:0] r_perf_fetch;
    logic [63:0] r_perf_stall;
    logic [63:0] r_perf_discard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch   <= 64'd0;
            r_perf_stall   <= 64'd0;
            r_perf_discard <= 64'd0;
        end else begin
            if (w_deliver) begin
                r_perf_fetch <= r_perf_fetch + 64'd1;
            end
            if (r_dv & stall) begin
                r_perf_stall <= r_perf_stall + 64'd1;
            end
            if (w_complete & (redirect | (r_state == DISCARD))) begin
                r_perf_discard <= r_perf_discard + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt   = r_perf_fetch;
    assign perf_stall_cnt   = r_perf_stall;
    assign perf_discard_cnt = r_perf_discard;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations,
// then randomized stall/redirect/reset/latency traffic checked against a queue-based model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;
    logic        dataF_valid;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
    logic [63:0] perf_discard_cnt;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(PCINIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .ireq             (ireq),
        .iresp            (iresp),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .dataF            (dataF),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_discard_cnt (perf_discard_cnt),
`endif
        .dataF_valid      (dataF_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered instructions as a queue (head = dataF), plus request flags.
    typedef struct {
        logic [31:0] raw;
        logic [63:0] pc;
    } instr_t;

    instr_t          m_q[$];
    logic [63:0]     m_pc    = PCINIT;
    logic [63:0]     m_daddr = 64'd0;
    bit              m_out   = 1'b0;
    bit              m_disc  = 1'b0;
    bit              m_live  = 1'b0;
    longint unsigned m_fetch = 0;
    longint unsigned m_stall = 0;
    longint unsigned m_drop  = 0;

    // Bus responder state.
    bit          b_pend = 1'b0;
    int          b_cnt  = 0;
    logic [63:0] b_addr = 64'd0;

    // Per-cycle observations for the literal expectations.
    int          idx = 0;
    logic        h_valid[64];
    logic [63:0] h_addr[64];
    logic        h_dv[64];
    fetch_data_t h_data[64];
`ifdef FETCH_PERF_EN
    logic [63:0] h_pf[64];
    logic [63:0] h_pd[64];
    logic [63:0] h_ps[64];
`endif

    function automatic logic [31:0] bus_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF ^ {a[15:0], a[31:16]};
    endfunction

    task automatic cycle(input bit st, input bit rd, input logic [63:0] rpc, input bit rs, input int lat);
        bit can_issue;
        bit exp_valid;
        bit comp;
        @(negedge clk);
        reset       = rs;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        iresp       = '0;
        #1;
        if (rs) begin
            b_pend = 1'b0;
        end else if (ireq.valid) begin
            if (!b_pend) begin
                b_pend        = 1'b1;
                b_cnt         = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
                b_addr        = ireq.addr;
                iresp.addr_ok = 1'b1;
            end else begin
                check("bus_hold_addr", ireq.addr, b_addr);
            end
            if (b_cnt == 0) begin
                iresp.data_ok = 1'b1;
                iresp.data    = {$urandom, bus_word(b_addr)};
                b_pend        = 1'b0;
            end else begin
                b_cnt--;
            end
        end
        #1;
        if (idx < 64) begin
            h_valid[idx] = ireq.valid;
            h_addr[idx]  = ireq.addr;
            h_dv[idx]    = dataF_valid;
            h_data[idx]  = dataF;
`ifdef FETCH_PERF_EN
            h_pf[idx] = perf_fetch_cnt;
            h_pd[idx] = perf_discard_cnt;
            h_ps[idx] = perf_stall_cnt;
`endif
        end
        idx++;

        can_issue = ((m_q.size() == 0) || (m_q.size() == 1 && !st)) && !rd;
        exp_valid = !rs && (m_out || m_disc || can_issue);
        check("ireq_valid", ireq.valid, exp_valid);
        if (!rs && m_live) begin
            if (exp_valid) check("ireq_addr", ireq.addr, m_disc ? m_daddr : m_pc);
            check("dataF_valid", dataF_valid, m_q.size() > 0);
            check("dataF_stall", dataF.stall, m_q.size() == 0);
            if (m_q.size() > 0) begin
                check("dataF_pc", dataF.pc, m_q[0].pc);
                check("dataF_raw", dataF.raw_instr, m_q[0].raw);
            end
`ifdef FETCH_PERF_EN
            check("perf_fetch", perf_fetch_cnt, m_fetch);
            check("perf_stall", perf_stall_cnt, m_stall);
            check("perf_discard", perf_discard_cnt, m_drop);
`endif
        end

        if (rs) begin
            m_q.delete();
            m_pc    = PCINIT;
            m_out   = 1'b0;
            m_disc  = 1'b0;
            m_fetch = 0;
            m_stall = 0;
            m_drop  = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            comp = exp_valid && iresp.data_ok;
            if (m_q.size() > 0 && st) m_stall++;
            if (rd) begin
                if (comp) begin
                    m_drop++;
                    m_disc = 1'b0;
                end else if (exp_valid && !m_disc) begin
                    m_disc  = 1'b1;
                    m_daddr = m_pc;
                end
                m_out = 1'b0;
                m_q.delete();
                m_pc = rpc;
            end else begin
                if (m_q.size() > 0 && !st) m_q.delete(0);
                if (comp && m_disc) begin
                    m_drop++;
                    m_disc = 1'b0;
                    m_out  = 1'b0;
                end else if (comp) begin
                    m_q.push_back('{raw: bus_word(m_pc), pc: m_pc});
                    m_fetch++;
                    m_pc  = m_pc + 64'd4;
                    m_out = (m_q.size() == 0) || (m_q.size() == 1 && !st);
                end else begin
                    m_out = exp_valid && !m_disc;
                end
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 0);
        idx = 0;
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        iresp       = '0;

        // Two-cycle bus latency: request addresses step by 4, dataF follows each data_ok.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 64'd0, 1'b0, 2);
        check("rst_dataF_raw", h_data[0].raw_instr, 64'd0);
        check("rst_dataF_pc", h_data[0].pc, 64'd0);
        check("rst_dataF_stall", h_data[0].stall, 64'd1);
        check("rst_dataF_valid", h_dv[0], 64'd0);
        check("a_first_addr", h_addr[0], 64'h8000_0000);
        check("a_addr1", h_addr[3], 64'h8000_0004);
        check("a_addr2", h_addr[6], 64'h8000_0008);
        check("a_dpc0", h_data[3].pc, 64'h8000_0000);
        check("a_dpc1", h_data[6].pc, 64'h8000_0004);
        check("a_dpc2", h_data[9].pc, 64'h8000_0008);

        // Five stalled cycles on a zero-wait bus: one skid capture, then drain in order.
        do_reset();
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 0);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 64'd0, 1'b0, 0);
        for (int i = 6; i <= 8; i++) cycle(1'b0, 1'b0, 64'd0, 1'b0, 0);
        check("b_skid_addr", h_addr[1], 64'h8000_0004);
        check("b_full_novalid", h_valid[5], 64'd0);
        check("b_dpc6", h_data[6].pc, 64'h8000_0000);
        check("b_dpc7", h_data[7].pc, 64'h8000_0004);
        check("b_dpc8", h_data[8].pc, 64'h8000_0008);
        check("b_dv8", h_dv[8], 64'd1);

        // Redirects: while pending, with data_ok, and twice during DISCARD; then mid-request reset.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 64'd0, 1'b0, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 3);
        cycle(1'b0, 1'b1, 64'h8000_1000, 1'b0, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1);
        cycle(1'b0, 1'b1, 64'h8000_1800, 1'b0, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 3);
        cycle(1'b0, 1'b1, 64'h8000_1C00, 1'b0, 0);
        cycle(1'b0, 1'b1, 64'h8000_2000, 1'b0, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 3);
        check("c_pending_addr", h_addr[4], 64'h8000_0010);
        check("c_hold_addr", h_addr[6], 64'h8000_0010);
        check("c_drop_addr", h_addr[7], 64'h8000_0010);
        check("c_drop_dv", h_dv[7], 64'd0);
        check("c_redir_addr", h_addr[8], 64'h8000_1000);
        check("c_samecyc_addr", h_addr[10], 64'h8000_1800);
        check("c_disc_hold", h_addr[12], 64'h8000_1800);
        check("c_last_target", h_addr[14], 64'h8000_2000);
        check("c_dv14", h_dv[14], 64'd0);
`ifdef FETCH_PERF_EN
        check("c_perf_discard", h_pd[14], 64'd3);
        check("c_perf_fetch", h_pf[14], 64'd4);
        check("c_perf_stall", h_ps[14], 64'd0);
`endif
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1);
        check("e_after_rst_valid", h_valid[17], 64'd1);
        check("e_after_rst_addr", h_addr[17], 64'h8000_0000);
        check("e_after_rst_dv", h_dv[17], 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit          st;
            bit          rd;
            bit          rs;
            logic [63:0] rpc;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            rs  = ($urandom_range(0, 299) == 0);
            rpc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
            cycle(st, rd, rpc, rs, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
